// File: rtl/scpu_debug_uart.sv
// Debug character sink for the single-cycle CPU: captures dump strobes into
// a FIFO, sends them as 8N1 UART frames and reports drain after halt.
module scpu_debug_uart #(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     debugDump,
   input  logic [7:0]               dumpChar,
   input  logic                     haltTriggered,
   output logic                     txd,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifoCount,
   output logic                     overflow,
   output logic [CNT_W-1:0]         dropCount,
   output logic                     drained
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [BW-1:0] BC_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   bc_q, bc_d;
   logic [2:0]      bi_q, bi_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic            ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic            dump_q;
   logic            halt_q;
   logic            drained_q;
   logic [7:0]      mem_q [DEPTH];

   logic push, pop, accept, drop;

   assign push   = debugDump & ~dump_q;
   // A pop in the same cycle frees the slot the push needs.
   assign accept = push & ((cnt_q < FULL) | pop);
   assign drop   = push & ~accept;

   always_comb begin
      state_d = state_q;
      bc_d    = bc_q;
      bi_d    = bi_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cnt_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               bc_d    = '0;
               state_d = START;
            end
         end
         START: begin
            if (bc_q == BC_MAX) begin
               bc_d    = '0;
               bi_d    = '0;
               state_d = DATA;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end
         DATA: begin
            if (bc_q == BC_MAX) begin
               bc_d    = '0;
               shift_d = shift_q >> 1;
               if (bi_q == 3'd7) state_d = STOP;
               else              bi_d    = bi_q + 1'b1;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end
         STOP: begin
            if (bc_q == BC_MAX) begin
               bc_d    = '0;
               state_d = IDLE;
            end else begin
               bc_d = bc_q + 1'b1;
            end
         end
      endcase
      // txd follows the state being entered so the pin is a flop output
      unique case (state_d)
         IDLE:  txd_d = 1'b1;
         START: txd_d = 1'b0;
         DATA:  txd_d = shift_d[0];
         STOP:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (accept) wptr_d = wptr_q + 1'b1;
      if (pop)    rptr_d = rptr_q + 1'b1;
      if (accept && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !accept) cnt_d = cnt_q - 1'b1;
      if (drop) begin
         ovf_d = 1'b1;
         if (!(&drop_q)) drop_d = drop_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         bc_q      <= '0;
         bi_q      <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         cnt_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         ovf_q     <= 1'b0;
         drop_q    <= '0;
         dump_q    <= 1'b1;
         halt_q    <= 1'b0;
         drained_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bc_q      <= bc_d;
         bi_q      <= bi_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         cnt_q     <= cnt_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
         dump_q    <= debugDump;
         halt_q    <= halt_q | haltTriggered;
         drained_q <= halt_q & (cnt_q == '0) & (state_q == IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset && accept) mem_q[wptr_q] <= dumpChar;
   end

   assign txd       = txd_q;
   assign busy      = (cnt_q != '0) | (state_q != IDLE);
   assign fifoCount = cnt_q;
   assign overflow  = ovf_q;
   assign dropCount = drop_q;
   assign drained   = drained_q;

endmodule

// File: tb/tb_scpu_debug_uart.sv
// Bench for scpu_debug_uart: frame table, corner sequences and a random run
// checked every cycle against a queue-based UART/FIFO reference model.
module tb_scpu_debug_uart;

   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int CNT_W = 3;
   localparam int FRAME = 10 * CPB;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             debugDump;
   logic [7:0]       dumpChar;
   logic             haltTriggered;
   logic             txd;
   logic             busy;
   logic [2:0]       fifoCount;
   logic             overflow;
   logic [CNT_W-1:0] dropCount;
   logic             drained;

   scpu_debug_uart #(
      .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .debugDump(debugDump),
      .dumpChar(dumpChar), .haltTriggered(haltTriggered),
      .txd(txd), .busy(busy), .fifoCount(fifoCount),
      .overflow(overflow), .dropCount(dropCount), .drained(drained)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus the start time of the frame on the wire.
   logic [7:0] mq[$];
   logic [7:0] m_byte;
   int  m_start = -100000;
   int  m_cyc = 0;
   bit  m_prev = 1'b1;
   bit  m_halt = 1'b0;
   bit  m_ovf = 1'b0;
   int  m_drops = 0;
   bit  m_drained = 1'b0;

   function automatic bit in_frame(input int m);
      return (m >= m_start) && (m < m_start + FRAME);
   endfunction

   function automatic bit exp_txd(input int m);
      int k;
      if (!in_frame(m)) return 1'b1;
      k = (m - m_start) / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_byte[k-1];
   endfunction

   function automatic void model_step();
      bit edge_s, pop_s, dn;
      m_cyc++;
      if (!reset) begin
         mq.delete();
         m_start = -100000;
         m_prev = 1'b1;
         m_halt = 1'b0;
         m_ovf = 1'b0;
         m_drops = 0;
         m_drained = 1'b0;
         return;
      end
      dn = m_halt && (mq.size() == 0) && !in_frame(m_cyc - 1);
      edge_s = debugDump && !m_prev;
      m_prev = debugDump;
      pop_s = (mq.size() > 0) && !in_frame(m_cyc - 1);
      if (pop_s) begin
         m_byte = mq.pop_front();
         m_start = m_cyc;
      end
      if (edge_s) begin
         if (mq.size() < DEPTH) mq.push_back(dumpChar);
         else begin
            m_ovf = 1'b1;
            if (m_drops < SAT) m_drops++;
         end
      end
      if (haltTriggered) m_halt = 1'b1;
      m_drained = dn;
   endfunction

   always begin
      @(posedge clk);
      model_step();
      #2;
      if (chk_en) begin
         check("txd", int'(txd), int'(exp_txd(m_cyc)));
         check("busy", int'(busy), int'((mq.size() > 0) || in_frame(m_cyc)));
         check("fifoCount", int'(fifoCount), mq.size());
         check("overflow", int'(overflow), int'(m_ovf));
         check("dropCount", int'(dropCount), m_drops);
         check("drained", int'(drained), int'(m_drained));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [7:0] c);
      debugDump = 1'b1;
      dumpChar = c;
      tick(1);
      debugDump = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         if (!busy) done = 1'b1;
         else tick(1);
      end
      check("idle_timeout", int'(done), 1);
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      debugDump = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   typedef struct {
      logic [7:0] ch;
      logic [0:9] pat;
      int         busy_cyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int busyc, maxc;
      vecs[0] = '{8'h41, 10'b0100000101, 41};
      vecs[1] = '{8'h55, 10'b0101010101, 41};
      vecs[2] = '{8'hA3, 10'b0110001011, 41};
      vecs[3] = '{8'h00, 10'b0000000001, 41};
      vecs[4] = '{8'hFF, 10'b0111111111, 41};

      reset = 1'b0;
      debugDump = 1'b0;
      dumpChar = 8'h00;
      haltTriggered = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(1);
      check("rst_txd", int'(txd), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_cnt", int'(fifoCount), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_drop", int'(dropCount), 0);
      check("rst_drained", int'(drained), 0);
      reset = 1'b1;
      tick(2);

      // Frame table
      foreach (vecs[v]) begin
         wait_idle();
         tick(2);
         pulse(vecs[v].ch);
         check("tbl_cnt", int'(fifoCount), 1);
         busyc = 0;
         for (int c = 0; c < 45; c++) begin
            if (c > 0) tick(1);
            if (busy) busyc++;
            if (c >= 2 && (c - 2) % CPB == 0 && (c - 2) / CPB < 10)
               check("tbl_txd", int'(txd), int'(vecs[v].pat[(c-2)/CPB]));
         end
         check("tbl_busy_len", busyc, vecs[v].busy_cyc);
      end

      // Held strobe: one capture only
      wait_idle();
      tick(2);
      debugDump = 1'b1;
      dumpChar = 8'h55;
      maxc = 0;
      busyc = 0;
      for (int c = 0; c < 60; c++) begin
         tick(1);
         if (c == 19) debugDump = 1'b0;
         if (int'(fifoCount) > maxc) maxc = int'(fifoCount);
         if (busy) busyc++;
      end
      check("held_maxcnt", maxc, 1);
      check("held_busy_len", busyc, 41);

      // Full FIFO with a push on the popping cycle
      reset_dut();
      pulse(8'h30);
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         pulse(8'h30 + 8'(i));
      end
      check("full_cnt", int'(fifoCount), 4);
      tick(33);
      pulse(8'hC3);
      check("fullpop_cnt", int'(fifoCount), 4);
      check("fullpop_ovf", int'(overflow), 0);
      check("fullpop_drop", int'(dropCount), 0);
      wait_idle();

      // Overflow, then saturation of the drop counter
      reset_dut();
      pulse(8'h10);
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         pulse(8'h10 + 8'(i));
      end
      check("ovf_flag", int'(overflow), 1);
      check("ovf_drop", int'(dropCount), 2);
      check("ovf_cnt", int'(fifoCount), 4);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         pulse(8'h80 + 8'(i));
      end
      check("sat_drop", int'(dropCount), SAT);
      check("sat_flag", int'(overflow), 1);
      wait_idle();

      // Halt and drain
      reset_dut();
      pulse(8'h48);
      tick(1);
      pulse(8'h49);
      tick(1);
      pulse(8'h21);
      haltTriggered = 1'b1;
      tick(1);
      check("halt_early", int'(drained), 0);
      tick(118);
      check("halt_last_idle", int'(drained), 0);
      tick(1);
      check("halt_drained", int'(drained), 1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("halt_stay", int'(drained), 1);
      end
      pulse(8'h0A);
      check("post_halt_cnt", int'(fifoCount), 1);
      tick(1);
      check("post_halt_undrain", int'(drained), 0);
      wait_idle();
      tick(1);
      check("post_halt_redrain", int'(drained), 1);

      // Reset in the middle of data bit 3, strobe held through release
      haltTriggered = 1'b0;
      reset_dut();
      pulse(8'h3C);
      tick(16);
      reset = 1'b0;
      debugDump = 1'b1;
      tick(1);
      check("midrst_txd", int'(txd), 1);
      check("midrst_cnt", int'(fifoCount), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_drained", int'(drained), 0);
      tick(2);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("held_release_cnt", int'(fifoCount), 0);
      end
      debugDump = 1'b0;
      tick(2);

      // Random traffic against the model
      reset_dut();
      for (int i = 0; i < 3000; i++) begin
         debugDump = ($urandom_range(0, 99) < 30);
         dumpChar = 8'($urandom);
         if (i == 2000) haltTriggered = 1'b1;
         reset = ($urandom_range(0, 999) != 0);
         tick(1);
      end
      reset = 1'b1;
      debugDump = 1'b0;
      wait_idle();
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/scpu_debug_uart.md
Name: scpu_debug_uart

Overview:
- Downstream consumer of the single-cycle CPU's debug outputs.
- On each rising edge of `debugDump`, captures the character byte (r2[7:0]) into a small FIFO and serialises it on a UART TX line (8N1, LSB first).
- Tracks `haltTriggered` and reports when all captured output has left the wire, so benches and board tops can stop cleanly instead of ending on the halt itself.

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CLKS_PER_BIT, 16: clk cycles per UART bit; ≥2.
- CNT_W, 8: width of the saturating dropped-character counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- debugDump  input  1  CPU debug strobe; level, may stay high several cycles.
- dumpChar  input  8  character byte, valid whenever debugDump is high.
- haltTriggered  input  1  CPU halt flag; level, sticky once set.
- txd  output  1  UART serial out, idle high.
- busy  output  1  high when FIFO is non-empty or the TX FSM is not IDLE.
- fifoCount  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a capture is dropped.
- dropCount  output  CNT_W  dropped captures, saturates at all-ones.
- drained  output  1  halt seen AND FIFO empty AND FSM IDLE.

Behaviour:
- Reset (reset==0 at posedge), all regardless of in-flight frame:
  - txd=1, busy=0, fifoCount=0, overflow=0, dropCount=0, drained=0, FSM=IDLE.
  - Edge-detect register=1, so a debugDump already high on release is NOT a capture.
  - haltSeen=0.
- Capture:
  - Rising edge = debugDump==1 at this posedge and 0 at the previous posedge. Exactly one push per edge.
  - Push writes dumpChar at that posedge; fifoCount increments the same posedge.
- Full handling:
  - Push accepted if fifoCount<DEPTH, or if a pop occurs in the same cycle; count unchanged in the simultaneous case.
  - Otherwise the byte is dropped, overflow←1, and dropCount increments unless already saturated.
  - A pop from an empty FIFO never occurs.
- FIFO is a circular buffer; read and write pointers wrap modulo DEPTH.
- TX FSM states are IDLE, START, DATA, STOP, with baud counter bc (0..CLKS_PER_BIT-1) and bit index bi (0..7).
  - IDLE: txd=1. If fifoCount>0, pop the head into the shift register, bc←0, go to START.
  - START: txd=0. When bc==CLKS_PER_BIT-1, bc←0, bi←0, go to DATA.
  - DATA: txd=shift[0]. On bc wrap, shift right; if bi==7 go to STOP, else bi++.
  - STOP: txd=1. On bc wrap, go to IDLE.
- Latency: capture at posedge E; pop and START entry at posedge E+1; txd low from E+1 for CLKS_PER_BIT cycles.
- Frame timing:
  - Frame is 10·CLKS_PER_BIT cycles.
  - Back-to-back frames have one extra IDLE cycle (txd=1), so the effective stop bit is CLKS_PER_BIT+1.
- txd is driven from a register (glitch-free).
- Halt and drain:
  - haltSeen←1 on any posedge with haltTriggered==1; cleared only by reset.
  - drained is registered: asserted the posedge after haltSeen && fifoCount==0 && FSM==IDLE holds, and remains high.
- Captures after halt are still accepted and transmitted. drained deasserts if the FIFO becomes non-empty.
- Simultaneous capture and halt in one cycle: the byte is queued; drained waits for it.

Test Plan:
- Single char: CLKS_PER_BIT=4, debugDump pulse with dumpChar=0x41 → txd reads 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 0x41, stop), 4 cycles each, starting 1 cycle after capture; busy high for exactly 40 cycles plus the capture cycle.
- Held strobe: debugDump high 20 cycles with dumpChar=0x55 → exactly one frame sent; fifoCount never exceeds 1.
- Overflow: DEPTH=4; 7 one-cycle pulses spaced 2 cycles apart while the first frame is in flight → 1 in flight + 4 queued, 2 dropped; overflow=1, dropCount=2; 5 frames emitted in order.
- Full plus pop: strobe on the exact cycle IDLE pops from a full FIFO → byte accepted, fifoCount stays 4, overflow stays 0.
- Halt drain: queue 3 chars then raise haltTriggered → drained=0 until the last stop bit plus IDLE, then 1 the next posedge and stays 1.
- Reset mid-frame: assert reset during DATA bit 3 → next posedge txd=1, fifoCount=0, FSM IDLE; debugDump held high through release is not captured.
